// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
// States, opcodes, ALU codes, select values and the decode bundle.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IF     = 4'd0,
        ST_ID     = 4'd1,
        ST_EXE_R  = 4'd2,
        ST_EXE_BR = 4'd3,
        ST_EXE_MA = 4'd4,
        ST_MEM    = 4'd5,
        ST_WB_R   = 4'd6,
        ST_WB_LD  = 4'd7,
        ST_TRAP   = 4'd8
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BGEZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_LUI = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SGN = 3'd4;
    localparam logic [2:0] ALU_AND = 3'd5;
    localparam logic [2:0] ALU_SLT = 3'd6;
    localparam logic [2:0] ALU_XOR = 3'd7;

    localparam logic [2:0] NPC_SEQ  = 3'b000;
    localparam logic [2:0] NPC_JUMP = 3'b001;
    localparam logic [2:0] NPC_BR   = 3'b011;
    localparam logic [2:0] NPC_JR   = 3'b100;
    localparam logic [2:0] NPC_EXC  = 3'b101;

    localparam logic [2:0] WB_ALU = 3'b000;
    localparam logic [2:0] WB_DM  = 3'b001;
    localparam logic [2:0] WB_LUI = 3'b011;
    localparam logic [2:0] WB_PC  = 3'b100;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_ILL  = 2'b01;
    localparam logic [1:0] CAUSE_BUS  = 2'b10;

    typedef struct packed {
        logic is_add;
        logic is_sub;
        logic is_and;
        logic is_or;
        logic is_xor;
        logic is_slt;
        logic is_jr;
        logic is_addi;
        logic is_addiu;
        logic is_ori;
        logic is_lui;
        logic is_lw;
        logic is_sw;
        logic is_beq;
        logic is_bgez;
        logic is_bgtz;
        logic is_j;
        logic is_jal;
        logic illegal;
    } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational op/funct decoder producing one-hot instruction flags.
// Anything outside the supported set raises the illegal flag.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output dec_t       o_dec
);

    // Map op (and funct for R-type) to exactly one flag
    always_comb begin
        o_dec = '0;
        if (i_op == OP_RTYPE) begin
            case (i_funct)
                FN_ADD:  o_dec.is_add = 1'b1;
                FN_SUB:  o_dec.is_sub = 1'b1;
                FN_AND:  o_dec.is_and = 1'b1;
                FN_OR:   o_dec.is_or  = 1'b1;
                FN_XOR:  o_dec.is_xor = 1'b1;
                FN_SLT:  o_dec.is_slt = 1'b1;
                FN_JR:   o_dec.is_jr  = 1'b1;
                default: o_dec.illegal = 1'b1;
            endcase
        end else begin
            case (i_op)
                OP_ADDI:  o_dec.is_addi  = 1'b1;
                OP_ADDIU: o_dec.is_addiu = 1'b1;
                OP_ORI:   o_dec.is_ori   = 1'b1;
                OP_LUI:   o_dec.is_lui   = 1'b1;
                OP_LW:    o_dec.is_lw    = 1'b1;
                OP_SW:    o_dec.is_sw    = 1'b1;
                OP_BEQ:   o_dec.is_beq   = 1'b1;
                OP_BGEZ:  o_dec.is_bgez  = 1'b1;
                OP_BGTZ:  o_dec.is_bgtz  = 1'b1;
                OP_J:     o_dec.is_j     = 1'b1;
                OP_JAL:   o_dec.is_jal   = 1'b1;
                default:  o_dec.illegal  = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mc_ctrl_hs.sv
// Multi-cycle MIPS control FSM with memory ready handshakes,
// bounded wait-state timeout and a trap state.
module mc_ctrl_hs
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTR_W = 5,
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          op,
    input  logic [5:0]          funct,
    input  logic                beqout,
    input  logic                bgezout,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic                imem_req,
    output logic                dmem_req,
    output logic                PCWE,
    output logic                IRWre,
    output logic                DMWrite,
    output logic                RegWrt,
    output logic [ALUCTR_W-1:0] ALUctr,
    output logic [2:0]          npc_sel,
    output logic [1:0]          ExtOp,
    output logic [1:0]          mux4_5sel,
    output logic [2:0]          mux4_32sel,
    output logic                mux2sel,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [3:0]          state_out
);

    state_e            r_state;
    logic [WAIT_W-1:0] r_wait;
    logic [1:0]        r_cause;

    state_e            w_next;
    logic [WAIT_W-1:0] w_wait_next;
    logic              w_cause_set;
    logic [1:0]        w_cause_val;
    logic              w_wait_hit;
    logic              w_waiting;
    logic              w_taken;
    logic [2:0]        w_alu;
    dec_t              w_dec;

    mc_decode u_dec (
        .i_op    (op),
        .i_funct (funct),
        .o_dec   (w_dec)
    );

    assign w_wait_hit = (r_wait == WAIT_W'(MAX_WAIT));
    assign w_taken    = (w_dec.is_beq  & beqout)
                      | (w_dec.is_bgez & bgezout)
                      | (w_dec.is_bgtz & bgezout & ~beqout);

    // State, wait counter and sticky trap cause registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IF;
            r_wait  <= '0;
            r_cause <= CAUSE_NONE;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_next;
            if (w_cause_set) begin
                r_cause <= w_cause_val;
            end
        end
    end

    // Next state and all control outputs; reset cycle forces outputs low
    always_comb begin
        w_next      = r_state;
        w_cause_set = 1'b0;
        w_cause_val = CAUSE_NONE;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        PCWE        = 1'b0;
        IRWre       = 1'b0;
        DMWrite     = 1'b0;
        RegWrt      = 1'b0;
        ALUctr      = '0;
        npc_sel     = NPC_SEQ;
        ExtOp       = 2'b00;
        mux4_5sel   = 2'b00;
        mux4_32sel  = WB_ALU;
        mux2sel     = 1'b0;
        trap        = 1'b0;
        w_alu       = ALU_LUI;

        unique case (1'b1)
            w_dec.is_add | w_dec.is_addi | w_dec.is_addiu
                | w_dec.is_lw | w_dec.is_sw:   w_alu = ALU_ADD;
            w_dec.is_sub | w_dec.is_beq:       w_alu = ALU_SUB;
            w_dec.is_or | w_dec.is_ori:        w_alu = ALU_OR;
            w_dec.is_bgez | w_dec.is_bgtz:     w_alu = ALU_SGN;
            w_dec.is_and:                      w_alu = ALU_AND;
            w_dec.is_slt:                      w_alu = ALU_SLT;
            w_dec.is_xor:                      w_alu = ALU_XOR;
            default:                           w_alu = ALU_LUI;
        endcase

        case (r_state)
            ST_IF: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    IRWre  = 1'b1;
                    PCWE   = 1'b1;
                    w_next = ST_ID;
                end else if (w_wait_hit) begin
                    w_next      = ST_TRAP;
                    w_cause_set = 1'b1;
                    w_cause_val = CAUSE_BUS;
                end
            end
            ST_ID: begin
                unique case (1'b1)
                    w_dec.illegal: begin
                        w_next      = ST_TRAP;
                        w_cause_set = 1'b1;
                        w_cause_val = CAUSE_ILL;
                    end
                    w_dec.is_j | w_dec.is_jal: begin
                        PCWE    = 1'b1;
                        npc_sel = NPC_JUMP;
                        w_next  = ST_IF;
                        if (w_dec.is_jal) begin
                            RegWrt     = 1'b1;
                            mux4_32sel = WB_PC;
                        end
                    end
                    w_dec.is_jr: begin
                        PCWE    = 1'b1;
                        npc_sel = NPC_JR;
                        w_next  = ST_IF;
                    end
                    w_dec.is_lw | w_dec.is_sw: w_next = ST_EXE_MA;
                    w_dec.is_beq | w_dec.is_bgez
                        | w_dec.is_bgtz:       w_next = ST_EXE_BR;
                    default:                   w_next = ST_EXE_R;
                endcase
            end
            ST_EXE_R:  w_next = ST_WB_R;
            ST_EXE_BR: begin
                if (w_taken) begin
                    PCWE    = 1'b1;
                    npc_sel = NPC_BR;
                end
                w_next = ST_IF;
            end
            ST_EXE_MA: w_next = ST_MEM;
            ST_MEM: begin
                dmem_req = 1'b1;
                DMWrite  = w_dec.is_sw;
                if (dmem_ready) begin
                    w_next = w_dec.is_lw ? ST_WB_LD : ST_IF;
                end else if (w_wait_hit) begin
                    w_next      = ST_TRAP;
                    w_cause_set = 1'b1;
                    w_cause_val = CAUSE_BUS;
                end
            end
            ST_WB_R: begin
                RegWrt     = 1'b1;
                mux4_32sel = w_dec.is_lui ? WB_LUI : WB_ALU;
                w_next     = ST_IF;
            end
            ST_WB_LD: begin
                RegWrt     = 1'b1;
                mux4_32sel = WB_DM;
                w_next     = ST_IF;
            end
            ST_TRAP: begin
                trap    = 1'b1;
                PCWE    = 1'b1;
                npc_sel = NPC_EXC;
                w_next  = ST_IF;
            end
            default: w_next = ST_IF;
        endcase

        if (r_state == ST_EXE_R  || r_state == ST_EXE_BR ||
            r_state == ST_EXE_MA || r_state == ST_MEM    ||
            r_state == ST_WB_R   || r_state == ST_WB_LD) begin
            ALUctr = ALUCTR_W'(w_alu);
        end

        if (r_state != ST_IF) begin
            ExtOp = w_dec.is_lui ? 2'b00 :
                    w_dec.is_ori ? 2'b01 : 2'b10;
            mux4_5sel = w_dec.is_jal ? 2'b11 :
                        (w_dec.is_addi | w_dec.is_addiu | w_dec.is_lui
                         | w_dec.is_lw | w_dec.is_ori) ? 2'b00 : 2'b01;
            mux2sel = w_dec.is_lw | w_dec.is_sw | w_dec.is_addi
                    | w_dec.is_addiu | w_dec.is_ori;
        end

        if (!rst) begin
            imem_req   = 1'b0;
            dmem_req   = 1'b0;
            PCWE       = 1'b0;
            IRWre      = 1'b0;
            DMWrite    = 1'b0;
            RegWrt     = 1'b0;
            ALUctr     = '0;
            npc_sel    = NPC_SEQ;
            ExtOp      = 2'b00;
            mux4_5sel  = 2'b00;
            mux4_32sel = WB_ALU;
            mux2sel    = 1'b0;
            trap       = 1'b0;
        end
    end

    // Counter runs only while a request waits in place; any move clears it
    always_comb begin
        w_waiting   = (r_state == ST_IF  && !imem_ready)
                   || (r_state == ST_MEM && !dmem_ready);
        w_wait_next = '0;
        if (w_waiting && w_next == r_state) begin
            w_wait_next = r_wait + WAIT_W'(1);
        end
    end

    assign trap_cause = r_cause;
    assign state_out  = r_state;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Directed bench for mc_ctrl_hs: per-instruction vector table
// plus hand sequences for reset behaviour.
module tb_mc_ctrl_hs;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       beqout;
    logic       bgezout;
    logic       imem_ready;
    logic       dmem_ready;
    logic       imem_req;
    logic       dmem_req;
    logic       PCWE;
    logic       IRWre;
    logic       DMWrite;
    logic       RegWrt;
    logic [4:0] ALUctr;
    logic [2:0] npc_sel;
    logic [1:0] ExtOp;
    logic [1:0] mux4_5sel;
    logic [2:0] mux4_32sel;
    logic       mux2sel;
    logic       trap;
    logic [1:0] trap_cause;
    logic [3:0] state_out;

    always #5 clk = ~clk;

    mc_ctrl_hs #(.ALUCTR_W(5), .MAX_WAIT(15), .WAIT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct      (funct),
        .beqout     (beqout),
        .bgezout    (bgezout),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .PCWE       (PCWE),
        .IRWre      (IRWre),
        .DMWrite    (DMWrite),
        .RegWrt     (RegWrt),
        .ALUctr     (ALUctr),
        .npc_sel    (npc_sel),
        .ExtOp      (ExtOp),
        .mux4_5sel  (mux4_5sel),
        .mux4_32sel (mux4_32sel),
        .mux2sel    (mux2sel),
        .trap       (trap),
        .trap_cause (trap_cause),
        .state_out  (state_out)
    );

    // id/dd: ready-low cycles for imem/dmem; cyc: cycles IF..back to IF
    // remaining fields: outputs expected in the last cycle before IF
    typedef struct {
        int op; int fn; int bq; int bg; int id; int dd; int cyc;
        int pcwe; int npc; int rw; int m32; int alu; int dmw;
        int trp; int cause; int ext; int m5; int m2;
    } vec_t;

    localparam int NV = 27;
    vec_t vt[NV];
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int n, ifk, memk, left;
        int f_req, f_irw;
        int l_pcwe, l_npc, l_rw, l_m32, l_alu, l_dmw;
        int l_trp, l_cause, l_ext, l_m5, l_m2;
        v = vt[i];
        n = 0; ifk = 0; memk = 0; left = 0;
        f_req = 0; f_irw = 0;
        l_pcwe = 0; l_npc = 0; l_rw = 0; l_m32 = 0; l_alu = 0;
        l_dmw = 0; l_trp = 0; l_cause = 0; l_ext = 0; l_m5 = 0;
        l_m2 = 0;
        op      = v.op[5:0];
        funct   = v.fn[5:0];
        beqout  = v.bq[0];
        bgezout = v.bg[0];
        do begin
            if (state_out == 4'd0) begin
                ifk++;
                imem_ready = (ifk > v.id);
            end else begin
                imem_ready = 1'b0;
            end
            if (state_out == 4'd5) begin
                memk++;
                dmem_ready = (memk > v.dd);
            end else begin
                dmem_ready = 1'b0;
            end
            #1;
            if (n == 0) begin
                f_req = int'(imem_req);
                f_irw = int'(IRWre);
            end
            l_pcwe  = int'(PCWE);
            l_npc   = int'(npc_sel);
            l_rw    = int'(RegWrt);
            l_m32   = int'(mux4_32sel);
            l_alu   = int'(ALUctr);
            l_dmw   = int'(DMWrite);
            l_trp   = int'(trap);
            l_cause = int'(trap_cause);
            l_ext   = int'(ExtOp);
            l_m5    = int'(mux4_5sel);
            l_m2    = int'(mux2sel);
            @(posedge clk);
            @(negedge clk);
            n++;
            if (state_out != 4'd0) left = 1;
        end while (!(left == 1 && state_out == 4'd0) && n < 40);
        chk($sformatf("v%0d cycles", i), n, v.cyc);
        chk($sformatf("v%0d if_req", i), f_req, 1);
        chk($sformatf("v%0d if_irw", i), f_irw, int'(v.id == 0));
        chk($sformatf("v%0d pcwe", i), l_pcwe, v.pcwe);
        chk($sformatf("v%0d npc", i), l_npc, v.npc);
        chk($sformatf("v%0d regwrt", i), l_rw, v.rw);
        chk($sformatf("v%0d m32", i), l_m32, v.m32);
        chk($sformatf("v%0d aluctr", i), l_alu, v.alu);
        chk($sformatf("v%0d dmwrite", i), l_dmw, v.dmw);
        chk($sformatf("v%0d trap", i), l_trp, v.trp);
        chk($sformatf("v%0d extop", i), l_ext, v.ext);
        chk($sformatf("v%0d m5", i), l_m5, v.m5);
        chk($sformatf("v%0d m2", i), l_m2, v.m2);
        if (v.trp != 0) begin
            chk($sformatf("v%0d cause", i), l_cause, v.cause);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;
        //           op    fn    bq bg id  dd cyc pc npc rw m32 alu dw tp ca ex m5 m2
        vt[0]  = '{'h00, 'h20, 0, 0, 0, 0, 4,  0, 0, 1, 0, 1, 0, 0, 0, 2, 1, 0};
        vt[1]  = '{'h00, 'h22, 0, 0, 0, 0, 4,  0, 0, 1, 0, 2, 0, 0, 0, 2, 1, 0};
        vt[2]  = '{'h00, 'h24, 0, 0, 0, 0, 4,  0, 0, 1, 0, 5, 0, 0, 0, 2, 1, 0};
        vt[3]  = '{'h00, 'h25, 0, 0, 0, 0, 4,  0, 0, 1, 0, 3, 0, 0, 0, 2, 1, 0};
        vt[4]  = '{'h00, 'h26, 0, 0, 0, 0, 4,  0, 0, 1, 0, 7, 0, 0, 0, 2, 1, 0};
        vt[5]  = '{'h00, 'h2a, 0, 0, 0, 0, 4,  0, 0, 1, 0, 6, 0, 0, 0, 2, 1, 0};
        vt[6]  = '{'h00, 'h08, 0, 0, 0, 0, 2,  1, 4, 0, 0, 0, 0, 0, 0, 2, 1, 0};
        vt[7]  = '{'h08, 'h00, 0, 0, 0, 0, 4,  0, 0, 1, 0, 1, 0, 0, 0, 2, 0, 1};
        vt[8]  = '{'h09, 'h00, 0, 0, 0, 0, 4,  0, 0, 1, 0, 1, 0, 0, 0, 2, 0, 1};
        vt[9]  = '{'h0d, 'h00, 0, 0, 0, 0, 4,  0, 0, 1, 0, 3, 0, 0, 0, 1, 0, 1};
        vt[10] = '{'h0f, 'h00, 0, 0, 0, 0, 4,  0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0};
        vt[11] = '{'h23, 'h00, 0, 0, 0, 0, 5,  0, 0, 1, 1, 1, 0, 0, 0, 2, 0, 1};
        vt[12] = '{'h23, 'h00, 0, 0, 0, 3, 8,  0, 0, 1, 1, 1, 0, 0, 0, 2, 0, 1};
        vt[13] = '{'h2b, 'h00, 0, 0, 0, 0, 4,  0, 0, 0, 0, 1, 1, 0, 0, 2, 1, 1};
        vt[14] = '{'h04, 'h00, 1, 0, 0, 0, 3,  1, 3, 0, 0, 2, 0, 0, 0, 2, 1, 0};
        vt[15] = '{'h04, 'h00, 0, 0, 0, 0, 3,  0, 0, 0, 0, 2, 0, 0, 0, 2, 1, 0};
        vt[16] = '{'h01, 'h00, 0, 1, 0, 0, 3,  1, 3, 0, 0, 4, 0, 0, 0, 2, 1, 0};
        vt[17] = '{'h01, 'h00, 0, 0, 0, 0, 3,  0, 0, 0, 0, 4, 0, 0, 0, 2, 1, 0};
        vt[18] = '{'h07, 'h00, 0, 1, 0, 0, 3,  1, 3, 0, 0, 4, 0, 0, 0, 2, 1, 0};
        vt[19] = '{'h07, 'h00, 1, 1, 0, 0, 3,  0, 0, 0, 0, 4, 0, 0, 0, 2, 1, 0};
        vt[20] = '{'h02, 'h00, 0, 0, 0, 0, 2,  1, 1, 0, 0, 0, 0, 0, 0, 2, 1, 0};
        vt[21] = '{'h03, 'h00, 0, 0, 0, 0, 2,  1, 1, 1, 4, 0, 0, 0, 0, 2, 3, 0};
        vt[22] = '{'h3f, 'h00, 0, 0, 0, 0, 3,  1, 5, 0, 0, 0, 0, 1, 1, 2, 1, 0};
        vt[23] = '{'h00, 'h3f, 0, 0, 0, 0, 3,  1, 5, 0, 0, 0, 0, 1, 1, 2, 1, 0};
        vt[24] = '{'h00, 'h20, 0, 0, 15, 0, 19, 0, 0, 1, 0, 1, 0, 0, 0, 2, 1, 0};
        vt[25] = '{'h00, 'h20, 0, 0, 16, 0, 17, 1, 5, 0, 0, 0, 0, 1, 2, 2, 1, 0};
        vt[26] = '{'h2b, 'h00, 0, 0, 0, 16, 20, 1, 5, 0, 0, 0, 0, 1, 2, 2, 1, 1};

        rst        = 1'b0;
        op         = 6'h00;
        funct      = 6'h20;
        beqout     = 1'b0;
        bgezout    = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst state", int'(state_out), 0);
        chk("rst imem_req", int'(imem_req), 0);
        chk("rst irwre", int'(IRWre), 0);
        chk("rst pcwe", int'(PCWE), 0);
        chk("rst npc", int'(npc_sel), 0);
        chk("rst cause", int'(trap_cause), 0);
        rst = 1'b1;
        #1;
        chk("post-rst imem_req", int'(imem_req), 1);

        for (int i = 0; i < NV; i++) begin
            run_vec(i);
        end

        op         = 6'h2b;
        funct      = 6'h00;
        beqout     = 1'b0;
        bgezout    = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        k = 0;
        while (state_out != 4'd5 && k < 10) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        chk("sw reach MEM", int'(state_out), 5);
        #1;
        chk("sw MEM dmwrite", int'(DMWrite), 1);
        chk("sw MEM dmem_req", int'(dmem_req), 1);
        chk("sw MEM cause held", int'(trap_cause), 2);
        rst = 1'b0;
        #1;
        chk("rst-cycle dmwrite", int'(DMWrite), 0);
        chk("rst-cycle dmem_req", int'(dmem_req), 0);
        @(posedge clk);
        @(negedge clk);
        chk("mid-MEM rst state", int'(state_out), 0);
        chk("mid-MEM rst dmwrite", int'(DMWrite), 0);
        chk("mid-MEM rst dmem_req", int'(dmem_req), 0);
        chk("mid-MEM rst cause", int'(trap_cause), 0);
        rst = 1'b1;
        #1;
        chk("after rst imem_req", int'(imem_req), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
